sort_readout: RTL and testbench
===============================

# sort_readout

Drain-side companion to the parallel sorter. Captures the sorter's finished array on its done pulse and streams it out one element per transfer over a valid/ready interface, in ascending or descending order. Also checks that the captured array is actually monotonic and flags violations, so downstream logic and benches can detect a faulty sort.

## Interface
- DATA_N, 4, number of elements per array (≥2)
- DATA_W, 4, element width in bits
- IDX_W, $clog2(DATA_N), width of the element index
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sorted_in  in  DATA_W × DATA_N (unpacked array)  sorter result; element 0 is the smallest when the sort is correct
- sort_done  in  1  one-cycle pulse; sorted_in is valid in that cycle
- descend  in  1  sampled with sort_done; 1 streams from element DATA_N-1 down to 0
- out_ready  in  1  downstream accepts out_data this cycle
- out_valid  out  1  out_data/out_idx/out_last are valid
- out_data  out  DATA_W  current element
- out_idx  out  IDX_W  position of the current element in the captured array
- out_last  out  1  current element is the final one of the array
- busy  out  1  an array is held and not yet fully transferred
- overrun  out  1  one-cycle pulse: a sort_done was dropped
- order_err  out  1  sticky: captured array is not non-decreasing from index 0 upward

## Operation
- States: IDLE, STREAM. Reset → IDLE.
- IDLE: when sort_done=1, copy sorted_in into the local buffer, latch descend, set the pointer to 0 (ascending) or DATA_N-1 (descending), and go to STREAM.
- STREAM: out_valid=1. out_data = buf[ptr], out_idx = ptr. out_last=1 when ptr is DATA_N-1 (ascending) or 0 (descending).
- A transfer is out_valid & out_ready. On each transfer the pointer steps by +1 (ascending) or -1 (descending).
  - A transfer with out_last=1 returns the block to IDLE.
  - If sort_done=1 in that same cycle, the block instead recaptures and stays in STREAM with no idle cycle.
- sort_done in STREAM without a final transfer is dropped. overrun pulses in the next cycle, and the buffer is not modified.
- Holding out_valid: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- order_err: evaluated on the captured array at capture time. It is set if any buf[i] > buf[i-1]... precisely, if any sorted_in[i] < sorted_in[i-1] for i = 1..DATA_N-1, using an unsigned compare. It is overwritten on every capture and cleared only by reset or by a clean capture.
- Equal elements are legal and do not set order_err.
- busy equals (state == STREAM).
- Reset mid-stream: all outputs return to reset values immediately, the buffer clears to 0, and any pending array is lost.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overrun=0, order_err=0.
- Capture latency: sort_done in cycle t → out_valid=1 with the first element in cycle t+1. order_err updates in cycle t+1.
- Throughput: one element per cycle while out_ready=1. A full array takes DATA_N cycles minimum.
- Final transfer in cycle t with no sort_done → out_valid=0 and busy=0 in cycle t+1.
- Outputs are registered; no combinational path exists from out_ready to out_valid.

## Structure
- Shared package sort_pkg:
  - readout_state_t enum (IDLE, STREAM)
  - default DATA_N and DATA_W constants, shared with the sorter so both ends agree on array shape
- One natural sub-module: sort_order_chk.
  - Purely combinational; DATA_N-1 adjacent compares reduced to a single violation bit.
  - Instantiated on sorted_in and registered into order_err at capture.

## Test plan
- Ascending stream: sorted_in={1,3,7,9} (idx0..3), descend=0, out_ready=1 → out_data 1,3,7,9 in cycles t+1..t+4; out_last only on 9; order_err=0; busy=0 at t+5.
- Descending with backpressure: same array, descend=1, out_ready toggling 1,0,0,1… → sequence 9,7,3,1 with out_idx 3,2,1,0; data held stable through every ready=0 cycle.
- Bad sort: sorted_in={2,5,4,8} → order_err=1 at t+1 and the stream still emits 2,5,4,8. A subsequent capture of {0,0,1,15} clears order_err; the equal elements are not flagged.
- Overrun and back-to-back:
  - sort_done mid-stream → overrun pulses one cycle and the stream continues unchanged.
  - sort_done coincident with the out_last transfer → new element 0 appears the next cycle, with busy held at 1.
- Reset mid-stream: assert rst_n=0 after two transfers → all outputs 0 asynchronously. After release, IDLE ignores out_ready and waits for the next sort_done.

Source files
------------

// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_pkg : array shape and readout state shared by sorter and drain  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package sort_pkg;

  localparam int SORT_DATA_N = 4;
  localparam int SORT_DATA_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } readout_state_t;

endpackage : sort_pkg
`default_nettype wire

// File: rtl/sort_readout_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_readout_if : valid/ready element stream from the readout block  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface sort_readout_if
  import sort_pkg::*;
#(
  parameter int DATA_W = SORT_DATA_W,
  parameter int IDX_W  = $clog2(SORT_DATA_N)
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface : sort_readout_if
`default_nettype wire

// File: rtl/sort_order_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_order_chk : flags any adjacent pair that decreases (unsigned)   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sort_order_chk #(
  parameter int DATA_N = 4,
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data [DATA_N],
  output logic              violation
);

  logic [DATA_N-2:0] w_lt;

  generate
    for (genvar i = 1; i < DATA_N; i++) begin : g_cmp
      assign w_lt[i-1] = (data[i] < data[i-1]);
    end
  endgenerate

  assign violation = |w_lt;

endmodule : sort_order_chk
`default_nettype wire

// File: rtl/sort_readout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort_readout : captures a sorted array and streams it out in order   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sort_readout
  import sort_pkg::*;
#(
  parameter int DATA_N = SORT_DATA_N,
  parameter int DATA_W = SORT_DATA_W,
  parameter int IDX_W  = $clog2(DATA_N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   sorted_in [DATA_N],
  input  logic                sort_done,
  input  logic                descend,
  sort_readout_if.master      stream,
  output logic                busy,
  output logic                overrun,
  output logic                order_err
);

  localparam logic [IDX_W-1:0] C_PTR_MAX = IDX_W'(DATA_N - 1);

  readout_state_t    r_state;
  readout_state_t    w_next;
  logic [DATA_W-1:0] r_buf [DATA_N];
  logic [IDX_W-1:0]  r_ptr;
  logic              r_desc;
  logic              r_overrun;
  logic              r_order_err;

  logic              w_xfer;
  logic              w_at_last;
  logic              w_fin;
  logic              w_capture;
  logic              w_drop;
  logic              w_viol;

  sort_order_chk #(
    .DATA_N (DATA_N),
    .DATA_W (DATA_W)
  ) u_order_chk (
    .data      (sorted_in),
    .violation (w_viol)
  );

  assign w_xfer    = (r_state == STREAM) && stream.out_ready;
  assign w_at_last = r_desc ? (r_ptr == '0) : (r_ptr == C_PTR_MAX);
  assign w_fin     = w_xfer && w_at_last;
  // A done pulse is only taken when idle or when it lands on the final transfer.
  assign w_capture = sort_done && ((r_state == IDLE) || w_fin);
  assign w_drop    = sort_done && (r_state == STREAM) && !w_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sort_done) w_next = STREAM;
      STREAM:  if (w_fin && !sort_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stream.out_valid = 1'b0;
    stream.out_data  = '0;
    stream.out_idx   = '0;
    stream.out_last  = 1'b0;
    busy             = 1'b0;
    if (r_state == STREAM) begin
      stream.out_valid = 1'b1;
      stream.out_data  = r_buf[r_ptr];
      stream.out_idx   = r_ptr;
      stream.out_last  = w_at_last;
      busy             = 1'b1;
    end
  end

  assign overrun   = r_overrun;
  assign order_err = r_order_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_N; i++) r_buf[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < DATA_N; i++) r_buf[i] <= sorted_in[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_desc      <= 1'b0;
      r_overrun   <= 1'b0;
      r_order_err <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_capture) begin
        r_desc      <= descend;
        r_ptr       <= descend ? C_PTR_MAX : '0;
        r_order_err <= w_viol;
      end else if (w_xfer && !w_at_last) begin
        r_ptr <= r_desc ? (r_ptr - IDX_W'(1)) : (r_ptr + IDX_W'(1));
      end
    end
  end

endmodule : sort_readout
`default_nettype wire

// File: tb/tb_sort_readout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sort_readout : directed and randomized checks of sort_readout     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_sort_readout;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] i;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sorted_in [4];
  logic       sort_done;
  logic       descend;
  logic       busy;
  logic       overrun;
  logic       order_err;

  int n_cmp = 0;
  int n_err = 0;

  ent_t m_q[$];
  bit   m_ov;
  bit   m_oe;

  sort_readout_if #(.DATA_W(4), .IDX_W(2)) rd_if ();

  sort_readout #(
    .DATA_N (4),
    .DATA_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sorted_in (sorted_in),
    .sort_done (sort_done),
    .descend   (descend),
    .stream    (rd_if),
    .busy      (busy),
    .overrun   (overrun),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  // Reference: the held array is a queue of (data, index) in emission order.
  task automatic tick(input bit done, input logic [15:0] a, input bit desc, input bit rdy);
    bit was_busy, xfer, fin, bad;
    int pos;
    sort_done       = done;
    descend         = desc;
    rd_if.out_ready = rdy;
    for (int i = 0; i < 4; i++) sorted_in[i] = a[4*i +: 4];
    was_busy = (m_q.size() != 0);
    xfer     = was_busy && rdy;
    fin      = xfer && (m_q.size() == 1);
    if (xfer) void'(m_q.pop_front());
    m_ov = was_busy && done && !fin;
    if (done && (!was_busy || fin)) begin
      m_q = {};
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        pos = desc ? 3 - k : k;
        m_q.push_back('{d: a[4*pos +: 4], i: 2'(pos)});
        if (k > 0 && a[4*k +: 4] < a[4*(k-1) +: 4]) bad = 1'b1;
      end
      m_oe = bad;
    end
    @(posedge clk);
    @(negedge clk);
    sort_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sort_done = 1'b0; descend = 1'b0; rd_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sorted_in[i] = '0;
    m_q = {}; m_ov = 0; m_oe = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rd_if.out_valid, rd_if.out_data, rd_if.out_idx, rd_if.out_last, busy, overrun, order_err} !== 11'd0) begin
      n_err++;
      $display("FAIL reset: got v=%b d=%0d i=%0d l=%b busy=%b ov=%b oe=%b, want all 0",
               rd_if.out_valid, rd_if.out_data, rd_if.out_idx, rd_if.out_last, busy, overrun, order_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ascending();
    logic [3:0] exp_d [4];
    exp_d = '{4'd1, 4'd3, 4'd7, 4'd9};
    tick(1'b1, 16'h9731, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rd_if.out_valid !== 1'b1 || rd_if.out_data !== exp_d[k] || rd_if.out_idx !== 2'(k) ||
          rd_if.out_last !== (k == 3) || order_err !== 1'b0) begin
        n_err++;
        $display("FAIL asc[%0d]: got v=%b d=%0d i=%0d l=%b oe=%b, want 1 %0d %0d %b 0",
                 k, rd_if.out_valid, rd_if.out_data, rd_if.out_idx, rd_if.out_last, order_err,
                 exp_d[k], k, (k == 3));
      end
      tick(1'b0, 16'h0, 1'b0, 1'b1);
    end
    n_cmp++;
    if (busy !== 1'b0 || rd_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL asc_end: got busy=%b v=%b, want 0 0", busy, rd_if.out_valid);
    end
  endtask

  task automatic test_descend_backpressure();
    logic [3:0] exp_d [4];
    int k, c;
    bit rdy;
    exp_d = '{4'd9, 4'd7, 4'd3, 4'd1};
    k = 0; c = 0;
    tick(1'b1, 16'h9731, 1'b1, 1'b1);
    while (k < 4 && c < 24) begin
      n_cmp++;
      if (rd_if.out_valid !== 1'b1 || rd_if.out_data !== exp_d[k] || rd_if.out_idx !== 2'(3 - k) ||
          rd_if.out_last !== (k == 3)) begin
        n_err++;
        $display("FAIL desc[c%0d]: got v=%b d=%0d i=%0d l=%b, want 1 %0d %0d %b",
                 c, rd_if.out_valid, rd_if.out_data, rd_if.out_idx, rd_if.out_last, exp_d[k], 3 - k, (k == 3));
      end
      rdy = (c % 4 == 0) || (c % 4 == 3);
      tick(1'b0, 16'h0, 1'b0, rdy);
      if (rdy) k++;
      c++;
    end
    n_cmp++;
    if (k != 4 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL desc_end: got sent=%0d busy=%b, want 4 0", k, busy);
    end
  endtask

  task automatic test_bad_sort();
    logic [3:0] exp_d [4];
    exp_d = '{4'd2, 4'd5, 4'd4, 4'd8};
    tick(1'b1, 16'h8452, 1'b0, 1'b1);
    n_cmp++;
    if (order_err !== 1'b1) begin
      n_err++;
      $display("FAIL bad_oe: got %b, want 1", order_err);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rd_if.out_valid !== 1'b1 || rd_if.out_data !== exp_d[k] || rd_if.out_idx !== 2'(k)) begin
        n_err++;
        $display("FAIL bad[%0d]: got v=%b d=%0d i=%0d, want 1 %0d %0d",
                 k, rd_if.out_valid, rd_if.out_data, rd_if.out_idx, exp_d[k], k);
      end
      tick(1'b0, 16'h0, 1'b0, 1'b1);
    end
    exp_d = '{4'd0, 4'd0, 4'd1, 4'd15};
    tick(1'b1, 16'hF100, 1'b0, 1'b1);
    n_cmp++;
    if (order_err !== 1'b0) begin
      n_err++;
      $display("FAIL clean_oe: got %b, want 0", order_err);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rd_if.out_data !== exp_d[k] || rd_if.out_last !== (k == 3)) begin
        n_err++;
        $display("FAIL clean[%0d]: got d=%0d l=%b, want %0d %b", k, rd_if.out_data, rd_if.out_last, exp_d[k], (k == 3));
      end
      tick(1'b0, 16'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_overrun();
    tick(1'b1, 16'h9731, 1'b0, 1'b0);
    n_cmp++;
    if (rd_if.out_data !== 4'd1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_start: got d=%0d ov=%b, want 1 0", rd_if.out_data, overrun);
    end
    tick(1'b1, 16'hFFFF, 1'b1, 1'b1);
    n_cmp++;
    if (overrun !== 1'b1 || rd_if.out_data !== 4'd3 || rd_if.out_idx !== 2'd1) begin
      n_err++;
      $display("FAIL ovr_pulse: got ov=%b d=%0d i=%0d, want 1 3 1", overrun, rd_if.out_data, rd_if.out_idx);
    end
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    n_cmp++;
    if (overrun !== 1'b0 || rd_if.out_data !== 4'd7) begin
      n_err++;
      $display("FAIL ovr_after: got ov=%b d=%0d, want 0 7", overrun, rd_if.out_data);
    end
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    n_cmp++;
    if (rd_if.out_data !== 4'd9 || rd_if.out_last !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_last: got d=%0d l=%b, want 9 1", rd_if.out_data, rd_if.out_last);
    end
    tick(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [4];
    exp_d = '{4'd13, 4'd12, 4'd11, 4'd10};
    tick(1'b1, 16'h4321, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 16'h0, 1'b0, 1'b1);
    n_cmp++;
    if (rd_if.out_data !== 4'd4 || rd_if.out_last !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_last: got d=%0d l=%b, want 4 1", rd_if.out_data, rd_if.out_last);
    end
    tick(1'b1, 16'hDCBA, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (busy !== 1'b1 || rd_if.out_valid !== 1'b1 || rd_if.out_data !== exp_d[k] ||
          rd_if.out_idx !== 2'(3 - k) || overrun !== 1'b0) begin
        n_err++;
        $display("FAIL b2b[%0d]: got busy=%b v=%b d=%0d i=%0d ov=%b, want 1 1 %0d %0d 0",
                 k, busy, rd_if.out_valid, rd_if.out_data, rd_if.out_idx, overrun, exp_d[k], 3 - k);
      end
      tick(1'b0, 16'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 16'h9731, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 16'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    m_q = {}; m_ov = 0; m_oe = 0;
    #1;
    n_cmp++;
    if ({rd_if.out_valid, rd_if.out_data, rd_if.out_idx, rd_if.out_last, busy, overrun, order_err} !== 11'd0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b d=%0d i=%0d l=%b busy=%b ov=%b oe=%b, want all 0",
               rd_if.out_valid, rd_if.out_data, rd_if.out_idx, rd_if.out_last, busy, overrun, order_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      n_cmp++;
      if (rd_if.out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset[%0d]: got v=%b busy=%b, want 0 0", k, rd_if.out_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    bit         ev, el;
    logic [3:0] ed;
    logic [1:0] ei;
    for (int c = 0; c < 400; c++) begin
      ev = (m_q.size() != 0);
      ed = ev ? m_q[0].d : 4'd0;
      ei = ev ? m_q[0].i : 2'd0;
      el = (m_q.size() == 1);
      n_cmp++;
      if (rd_if.out_valid !== ev || busy !== ev || rd_if.out_data !== ed || rd_if.out_idx !== ei ||
          rd_if.out_last !== el || overrun !== m_ov || order_err !== m_oe) begin
        n_err++;
        $display("FAIL rand[%0d]: got v=%b b=%b d=%0d i=%0d l=%b ov=%b oe=%b, want %b %b %0d %0d %b %b %b",
                 c, rd_if.out_valid, busy, rd_if.out_data, rd_if.out_idx, rd_if.out_last, overrun, order_err,
                 ev, ev, ed, ei, el, m_ov, m_oe);
      end
      tick(($urandom_range(0, 4) == 0), 16'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descend_backpressure();
    test_bad_sort();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sort_readout
`default_nettype wire
